// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one signed WIDTH x WIDTH product per WIDTH steps.
// Define BOOTH_EARLY_TERM_EN to finish early once the remaining multiplier bits are uniform.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 sub_sel
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CntW-1:0]  k_q, k_d;

  logic             add_en;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             early;
  logic [2*WIDTH:0] aq_shift;

  // Conditional-invert adder: subtract is A + (M ^ 1..1) + 1.
  always_comb begin
    sub_sel = (state_q == StCalc) && q_q[0] && !qm1_q;
    add_en  = (state_q == StCalc) && (q_q[0] ^ qm1_q);
    addend  = add_en ? (m_q ^ {(WIDTH + 1){sub_sel}}) : '0;
    sum     = a_q + addend + {{WIDTH{1'b0}}, sub_sel};
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CntW:0]    sh_amt;

  // Unconsumed multiplier bits sit in q_q[WIDTH-1-k:0]; if they all match q_m1 no add/sub remains.
  always_comb begin
    rem_mask = {WIDTH{1'b1}} >> k_q;
    early    = ((q_q & rem_mask) == ({WIDTH{qm1_q}} & rem_mask));
    sh_amt   = (CntW + 1)'(WIDTH) - (CntW + 1)'(k_q);
    aq_shift = $signed({a_q, q_q}) >>> sh_amt;
  end
`else
  always_comb begin
    early    = 1'b0;
    aq_shift = '0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    k_d       = k_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    product   = out_valid ? {a_q[WIDTH-1:0], q_q} : '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          k_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (early) begin
          a_d     = aq_shift[2*WIDTH:WIDTH];
          q_d     = aq_shift[WIDTH-1:0];
          qm1_d   = 1'b0;
          state_d = StDone;
        end else begin
          a_d   = {sum[WIDTH], sum[WIDTH:1]};
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
          k_d   = k_q + CntW'(1);
          if (k_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      k_q     <= k_d;
    end
  end

endmodule
